// File: rtl/parser.sv
// ASCII expression parser: "<digits><op><digits><term>" into two operands and an op.
// Holds the result until the arithmetic stage acknowledges it with calc_done.
module parser #(
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        calc_done,
  output logic [15:0] src1,
  output logic [15:0] src2,
  output logic [1:0]  op,
  output logic        parser_done,
  output logic        parse_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, SRC1, SRC2, DONE, WAIT, FLUSH
  } state_t;

  state_t      state, state_n;
  logic [15:0] acc1, acc1_n;
  logic [15:0] acc2, acc2_n;
  logic [1:0]  opr, opr_n;
  logic        have2, have2_n;
  logic        err_q, err_n;
  logic        load;

  logic        is_dig, is_term;
  logic        is_sp, is_op;
  logic [1:0]  op_code;
  logic [19:0] mac1, mac2;
  logic        ovf1, ovf2;

  assign is_dig  = (rx_data >= 8'h30) &&
                   (rx_data <= 8'h39);
  assign is_term = (rx_data == TERM_CHAR) ||
                   (rx_data == 8'h3D);
  assign is_sp   = (rx_data == 8'h20);

  always_comb begin
    is_op   = 1'b1;
    op_code = 2'd0;
    unique case (rx_data)
      8'h2B:   op_code = 2'd0;
      8'h2D:   op_code = 2'd1;
      8'h2A:   op_code = 2'd2;
      8'h2F:   op_code = 2'd3;
      default: is_op = 1'b0;
    endcase
  end

  // Wide multiply-accumulate so an overflow is seen, not wrapped.
  assign mac1 = {4'd0, acc1} * 20'd10 +
                {16'd0, rx_data[3:0]};
  assign mac2 = {4'd0, acc2} * 20'd10 +
                {16'd0, rx_data[3:0]};
  assign ovf1 = mac1 > 20'd65535;
  assign ovf2 = mac2 > 20'd65535;

  always_comb begin
    state_n = state;
    acc1_n  = acc1;
    acc2_n  = acc2;
    opr_n   = opr;
    have2_n = have2;
    err_n   = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: if (rx_valid) begin
        unique case (1'b1)
          is_dig: begin
            state_n = SRC1;
            acc1_n  = {12'd0, rx_data[3:0]};
          end
          is_sp: ;
          is_term: err_n = 1'b1;
          default: begin
            state_n = FLUSH;
            err_n   = 1'b1;
          end
        endcase
      end
      SRC1: if (rx_valid) begin
        unique case (1'b1)
          is_dig: begin
            if (ovf1) begin
              state_n = FLUSH;
              err_n   = 1'b1;
            end else begin
              acc1_n = mac1[15:0];
            end
          end
          is_op: begin
            state_n = SRC2;
            opr_n   = op_code;
            acc2_n  = 16'd0;
            have2_n = 1'b0;
          end
          is_sp: ;
          is_term: begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
          default: begin
            state_n = FLUSH;
            err_n   = 1'b1;
          end
        endcase
      end
      SRC2: if (rx_valid) begin
        unique case (1'b1)
          is_dig: begin
            if (ovf2) begin
              state_n = FLUSH;
              err_n   = 1'b1;
            end else begin
              acc2_n  = mac2[15:0];
              have2_n = 1'b1;
            end
          end
          is_sp: ;
          is_term: begin
            if (have2) begin
              state_n = DONE;
              load    = 1'b1;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          end
          default: begin
            state_n = FLUSH;
            err_n   = 1'b1;
          end
        endcase
      end
      DONE: state_n = WAIT;
      WAIT: if (calc_done) state_n = IDLE;
      FLUSH: if (rx_valid && is_term)
        state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are loaded on entry to DONE so they are valid with parser_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc1  <= 16'd0;
      acc2  <= 16'd0;
      opr   <= 2'd0;
      have2 <= 1'b0;
      err_q <= 1'b0;
      src1  <= 16'd0;
      src2  <= 16'd0;
      op    <= 2'd0;
    end else begin
      state <= state_n;
      acc1  <= acc1_n;
      acc2  <= acc2_n;
      opr   <= opr_n;
      have2 <= have2_n;
      err_q <= err_n;
      if (load) begin
        src1 <= acc1;
        src2 <= acc2;
        op   <= opr;
      end
    end
  end

  assign parser_done = (state == DONE);
  assign parse_err   = err_q;
  assign busy        = (state == DONE) ||
                       (state == WAIT);

endmodule

// File: tb/tb_parser.sv
// Bench for parser: expected pulses are queued as bytes are sent
// and checked by a monitor when parser_done or parse_err fires.
module tb_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        calc_done;
  logic [15:0] src1, src2;
  logic [1:0]  op;
  logic        parser_done, parse_err, busy;

  parser dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .calc_done(calc_done),
    .src1(src1), .src2(src2), .op(op),
    .parser_done(parser_done),
    .parse_err(parse_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [1:0]  o;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (parser_done || parse_err) begin
      int   ak;
      exp_t e;
      ak = (parser_done ? 1 : 0) + (parse_err ? 2 : 0);
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: kind=%0d cyc=%0d, required no pulse",
                 ak, cyc);
      end else begin
        e = q.pop_front();
        if (ak != e.kind || cyc != e.cyc ||
            (e.kind == 1 &&
             (src1 != e.s1 || src2 != e.s2 || op != e.o))) begin
          n_err++;
          $display("FAIL pulse: kind=%0d cyc=%0d src1=%0d src2=%0d op=%0d, required kind=%0d cyc=%0d src1=%0d src2=%0d op=%0d",
                   ak, cyc, src1, src2, op,
                   e.kind, e.cyc, e.s1, e.s2, e.o);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b, input int kind,
                      input logic [15:0] s1, input logic [15:0] s2,
                      input logic [1:0] o);
    exp_t e;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (kind != 0) begin
      e.kind = kind;
      e.cyc  = cyc + 1;
      e.s1   = s1;
      e.s2   = s2;
      e.o    = o;
      q.push_back(e);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h2B;
  endtask

  task automatic expr(input string s, input int kind, input int at,
                      input logic [15:0] s1, input logic [15:0] s2,
                      input logic [1:0] o);
    for (int i = 0; i < s.len(); i++)
      send(s[i], (i == at) ? kind : 0, s1, s2, o);
  endtask

  task automatic calc();
    @(negedge clk);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_src1"}, int'(src1), 0);
    chk({tag, "_src2"}, int'(src2), 0);
    chk({tag, "_op"}, int'(op), 0);
    chk({tag, "_done"}, int'(parser_done), 0);
    chk({tag, "_err"}, int'(parse_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    calc_done = 1'b0;
    repeat (3) @(negedge clk);
    zero_chk("reset");
    rst = 1'b0;

    expr("12+34\015", 1, 5, 16'd12, 16'd34, 2'd0);
    chk("busy_wait", int'(busy), 1);
    repeat (5) @(negedge clk);
    chk("busy_hold", int'(busy), 1);
    calc();
    chk("busy_clear", int'(busy), 0);

    expr("65535 * 2=", 1, 9, 16'd65535, 16'd2, 2'd2);
    calc();
    expr("65536+1\015", 2, 4, 16'd0, 16'd0, 2'd0);
    chk("ovf_src1_hold", int'(src1), 65535);
    chk("ovf_busy", int'(busy), 0);
    expr("3-1\015", 1, 3, 16'd3, 16'd1, 2'd1);
    calc();

    expr("7+\015", 2, 2, 16'd0, 16'd0, 2'd0);
    chk("term2_src1", int'(src1), 3);
    chk("term2_src2", int'(src2), 1);

    expr("1+2\015", 1, 3, 16'd1, 16'd2, 2'd0);
    expr("9-3\015", 0, -1, 16'd0, 16'd0, 2'd0);
    chk("wait_src1", int'(src1), 1);
    chk("wait_src2", int'(src2), 2);
    chk("wait_busy", int'(busy), 1);
    calc();
    expr("4/2\015", 1, 3, 16'd4, 16'd2, 2'd3);
    calc();

    expr("5x3\015", 2, 1, 16'd0, 16'd0, 2'd0);
    expr("8+8\015", 1, 3, 16'd8, 16'd8, 2'd0);
    calc();

    expr("+5\015", 2, 0, 16'd0, 16'd0, 2'd0);
    expr("\015", 2, 0, 16'd0, 16'd0, 2'd0);
    expr("1++2\015", 2, 2, 16'd0, 16'd0, 2'd0);
    expr("1/:\015", 2, 2, 16'd0, 16'd0, 2'd0);
    expr("6*", 0, -1, 16'd0, 16'd0, 2'd0);
    calc();
    expr("7 \015", 1, 2, 16'd6, 16'd7, 2'd2);
    calc();
    expr("1+65536\015", 2, 6, 16'd0, 16'd0, 2'd0);
    chk("ovf2_src1", int'(src1), 6);

    expr("12+3", 0, -1, 16'd0, 16'd0, 2'd0);
    @(negedge clk);
    rst       = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h0D;
    calc_done = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    calc_done = 1'b0;
    zero_chk("abort");
    @(negedge clk);
    rst = 1'b0;
    expr("1+1\015", 1, 3, 16'd1, 16'd1, 2'd0);
    calc();

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1);
  end

endmodule

// File: doc/parser.md
PARSER -- requirements
Module: parser

Interface
REQ-001 SHALL provide parameter TERM_CHAR, default 8'h0D, expression terminator byte; '=' (8'h3D) is also always a terminator.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port rx_data  input  8  ASCII byte from UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 SHALL have port calc_done  input  1  one-cycle pulse from the arithmetic stage: result captured.
REQ-007 SHALL have port src1  output  16  first operand, unsigned binary.
REQ-008 SHALL have port src2  output  16  second operand, unsigned binary.
REQ-009 SHALL have port op  output  2  operator: 0 '+', 1 '-', 2 '*', 3 '/'.
REQ-010 SHALL have port parser_done  output  1  one-cycle pulse: src1/src2/op valid.
REQ-011 SHALL have port parse_err  output  1  one-cycle pulse: malformed expression dropped.
REQ-012 SHALL have port busy  output  1  high in DONE and WAIT.

Function
REQ-013 SHALL accept the grammar: digits1, operator, digits2, terminator; byte 8'h20 (space) ignored in IDLE, SRC1, SRC2.
REQ-014 SHALL implement states IDLE, SRC1, SRC2, DONE, WAIT, FLUSH.
REQ-015 SHALL, in IDLE, on a digit move to SRC1 with acc1 = digit; on space stay; any other byte -> FLUSH with parse_err (a terminator byte instead returns to IDLE, parse_err pulsed).
REQ-016 SHALL, in SRC1, on digit set acc1 = acc1*10 + digit; on '+','-','*','/' latch op and go to SRC2 with digit count 0.
REQ-017 SHALL, in SRC2, on digit set acc2 = acc2*10 + digit; on terminator with at least one src2 digit go to DONE.
REQ-018 SHALL treat as error: non-grammar byte, terminator in SRC1, terminator or operator in SRC2 before any digit, second operator, accumulator result > 65535 (computed at >= 20 bits, never wrapped).
REQ-019 SHALL, on error, pulse parse_err the cycle after the offending byte and enter FLUSH, dropping bytes until a terminator, then IDLE; if the offending byte is itself a terminator, go directly to IDLE.
REQ-020 SHALL, in DONE (one cycle), load src1/src2/op from accumulators and pulse parser_done the same cycle; next state WAIT.
REQ-021 SHALL hold src1, src2, op stable from DONE until the next DONE.
REQ-022 SHALL, in WAIT, drop all rx bytes (no error) and return to IDLE the cycle after calc_done=1.
REQ-023 SHALL ignore calc_done in every state other than WAIT.
REQ-024 SHALL act only on bytes with rx_valid=1; rx_data is don't-care otherwise.
REQ-025 SHALL give parser_done latency of exactly 1 cycle after the terminator strobe.
REQ-026 SHALL digit-decode bytes 8'h30..8'h39 only; all other bytes are non-digits.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, force state IDLE, acc1=acc2=0, src1=src2=0, op=0, parser_done=0, parse_err=0, busy=0.
REQ-028 SHALL let rst abort any state mid-expression; no parser_done or parse_err pulse results from the aborted expression.
REQ-029 SHALL give rst priority over rx_valid and calc_done in the same cycle.

Verification
REQ-030 SHALL pass: "12+34\r" -> one parser_done, src1=12, src2=34, op=0, busy high until calc_done.
REQ-031 SHALL pass: "65535 * 2=" -> src1=65535, src2=2, op=2; "65536+1\r" -> parse_err, no parser_done, next valid expression parses.
REQ-032 SHALL pass: "7+\r" -> parse_err on the '\r', state IDLE, src1/src2 unchanged.
REQ-033 SHALL pass: "1+2\r" then "9-3\r" sent before calc_done -> second expression dropped, no error; after calc_done "4/2\r" yields src1=4, src2=2, op=3.
REQ-034 SHALL pass: "5x3\r" -> parse_err one cycle after 'x', remaining bytes flushed to '\r', then "8+8\r" -> src1=8, src2=8.
REQ-035 SHALL pass: rst asserted after "12+3" -> all outputs zero, no pulses; "1+1\r" afterwards parses normally.
